uart_rxsm: RTL

Receive state machine for the SSP UART, the counterpart of the transmit state machine. It oversamples the serial input at 16x the baud rate and validates the start bit at mid-bit. It then assembles 7- or 8-bit data LSB first, checks parity and stop bits, and writes the received word with its error flags into the receive FIFO. It sits between the RxD pad, after the baud rate generator's CE_16x, and the receive FIFO, and shares the format inputs (Len, NumStop, ParEn, Par) with the transmitter.

---
 rtl/uart_rxsm_if.sv | 32 +++
 rtl/uart_rxsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxsm_if.sv
// Port bundle for the UART receive state machine: baud tick, frame format,
// serial input, FIFO write side and decoded state status.
interface uart_rxsm_if;
    logic       CE_16x;
    logic       Len;
    logic       NumStop;
    logic       ParEn;
    logic [1:0] Par;
    logic       RxD;
    logic       RF_FF;

    logic       RF_WE;
    logic [7:0] RDR;
    logic       PE;
    logic       FE;
    logic       BRK;
    logic       OE;
    logic       RxIdle;
    logic       RxStart;
    logic       RxShift;
    logic       RxStop;

    modport master (
        input  CE_16x, Len, NumStop, ParEn, Par, RxD, RF_FF,
        output RF_WE, RDR, PE, FE, BRK, OE, RxIdle, RxStart, RxShift, RxStop
    );

    modport slave (
        output CE_16x, Len, NumStop, ParEn, Par, RxD, RF_FF,
        input  RF_WE, RDR, PE, FE, BRK, OE, RxIdle, RxStart, RxShift, RxStop
    );
endinterface

// File: rtl/uart_rxsm.sv
// UART receive state machine: 16x oversampled start validation, 7/8-bit LSB-first
// assembly, parity/stop/break checking and receive FIFO write with overrun pulse.
module uart_rxsm (
    input  logic        Clk,
    input  logic        Rst,
    uart_rxsm_if.master rx
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StStartBit = 4'd1,
        StShift0   = 4'd2,
        StShift1   = 4'd3,
        StShift2   = 4'd4,
        StShift3   = 4'd5,
        StShift4   = 4'd6,
        StShift5   = 4'd7,
        StShift6   = 4'd8,
        StShift7   = 4'd9,
        StParity   = 4'd10,
        StStop1    = 4'd11,
        StStop2    = 4'd12,
        StBreak    = 4'd13
    } state_e;

    state_e     state_q, state_d;
    logic       rx_meta_q, rxs_q;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic       par_bit_q, par_bit_d;
    logic       stop1_q, stop1_d;
    logic       zero_q, zero_d;
    logic [7:0] rdr_q, rdr_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       brk_q, brk_d;
    logic       rf_we_q, rf_we_d;
    logic       oe_q, oe_d;

    logic       sample;
    logic       has_par;
    logic       done;
    logic [7:0] word;
    logic       word_par;
    logic       pe_calc;
    logic       fe_calc;
    logic       frame_zero;

    always_comb begin
        sample   = rx.CE_16x && (bit_cnt_q == 4'd7);
        has_par  = rx.ParEn | rx.Len;
        // 7-bit frames leave the data sitting in the upper bits of the shifter
        word     = rx.Len ? {1'b0, data_q[7:1]} : data_q;
        word_par = (^word) ^ par_bit_q;
        case (rx.Par)
            2'd0:    pe_calc = ~word_par;
            2'd1:    pe_calc = word_par;
            2'd2:    pe_calc = par_bit_q;
            default: pe_calc = ~par_bit_q;
        endcase
        fe_calc    = ~rxs_q | ((state_q == StStop2) & ~stop1_q);
        frame_zero = zero_q & ~rxs_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        stop1_d   = stop1_q;
        zero_d    = zero_q;
        done      = 1'b0;

        if (rx.CE_16x) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d = 4'd0;
                if (rx.CE_16x && !rxs_q) begin
                    state_d = StStartBit;
                end
            end
            StStartBit: begin
                if (sample) begin
                    state_d = rxs_q ? StIdle : StShift0;
                    zero_d  = 1'b1;
                end
            end
            StShift0, StShift1, StShift2, StShift3, StShift4, StShift5: begin
                if (sample) begin
                    data_d  = {rxs_q, data_q[7:1]};
                    zero_d  = zero_q & ~rxs_q;
                    state_d = state_e'(state_q + 4'd1);
                end
            end
            StShift6: begin
                if (sample) begin
                    data_d  = {rxs_q, data_q[7:1]};
                    zero_d  = zero_q & ~rxs_q;
                    state_d = rx.Len ? StParity : StShift7;
                end
            end
            StShift7: begin
                if (sample) begin
                    data_d  = {rxs_q, data_q[7:1]};
                    zero_d  = zero_q & ~rxs_q;
                    state_d = rx.ParEn ? StParity : StStop1;
                end
            end
            StParity: begin
                if (sample) begin
                    par_bit_d = rxs_q;
                    zero_d    = zero_q & ~rxs_q;
                    state_d   = StStop1;
                end
            end
            StStop1: begin
                if (sample) begin
                    stop1_d = rxs_q;
                    zero_d  = zero_q & ~rxs_q;
                    if (rx.NumStop) begin
                        state_d = StStop2;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            StStop2: begin
                if (sample) begin
                    done = 1'b1;
                end
            end
            StBreak: begin
                if (rx.CE_16x && rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (rx.CE_16x) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Leave at mid stop bit so a back-to-back start edge is not missed;
        // after a break, hold off until the line has returned high.
        if (done) begin
            state_d = frame_zero ? StBreak : StIdle;
        end
    end

    always_comb begin
        rdr_d   = rdr_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        rf_we_d = 1'b0;
        oe_d    = 1'b0;
        if (done) begin
            if (rx.RF_FF) begin
                oe_d = 1'b1;
            end else begin
                rf_we_d = 1'b1;
                rdr_d   = word;
                pe_d    = has_par & pe_calc;
                fe_d    = fe_calc;
                brk_d   = frame_zero;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            data_q    <= 8'd0;
            par_bit_q <= 1'b0;
            stop1_q   <= 1'b1;
            zero_q    <= 1'b0;
            rdr_q     <= 8'd0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            brk_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx.RxD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            stop1_q   <= stop1_d;
            zero_q    <= zero_d;
            rdr_q     <= rdr_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            brk_q     <= brk_d;
            rf_we_q   <= rf_we_d;
            oe_q      <= oe_d;
        end
    end

    assign rx.RF_WE   = rf_we_q;
    assign rx.OE      = oe_q;
    assign rx.RDR     = rdr_q;
    assign rx.PE      = pe_q;
    assign rx.FE      = fe_q;
    assign rx.BRK     = brk_q;
    assign rx.RxIdle  = (state_q == StIdle);
    assign rx.RxStart = (state_q == StStartBit);
    assign rx.RxShift = (state_q >= StShift0) && (state_q <= StParity);
    assign rx.RxStop  = (state_q == StStop1) || (state_q == StStop2) || (state_q == StBreak);

endmodule
